axi_lite_bridge: RTL and testbench

- Converts one AXI4 slave port (crossbar peripheral side, 5-bit ID) into a single AXI4-Lite master port for memory-mapped I/O such as the GPIO window.
- Splits every AXI4 burst into one Lite transaction per beat.
- Echoes IDs and aggregates write responses.
- Read and write paths are independent and may run concurrently.

---
 rtl/axi_lite_bridge_pkg.sv | 32 +++
 rtl/axi_lite_bridge_addr_gen.sv | 20 ++
 rtl/axi_lite_bridge.sv | 360 ++++++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_bridge_pkg.sv
// rtl/axi_lite_bridge_pkg.sv - burst/response encodings and FSM states for the AXI4 to AXI4-Lite bridge
package axi_lite_bridge_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    RD_OUT  = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_BEAT  = 2'd1,
    WR_LRESP = 2'd2,
    WR_BRESP = 2'd3
  } wr_state_e;

  // Worst response wins when folding per-beat responses into one B.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/axi_lite_bridge_addr_gen.sv
// rtl/axi_lite_bridge_addr_gen.sv - next beat address and error-burst detection
module axi_lite_bridge_addr_gen #(
  parameter int ADDR_WIDTH = 64,
  parameter int STRB_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  err_o
);
  import axi_lite_bridge_pkg::*;

  localparam logic [2:0]            MAX_SIZE = 3'($clog2(STRB_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  assign err_o       = (burst_i == BURST_WRAP) || (size_i > MAX_SIZE);
  assign next_addr_o = (burst_i == BURST_INCR) ? addr_i + (ONE << size_i) : addr_i;

endmodule

// File: rtl/axi_lite_bridge.sv
// rtl/axi_lite_bridge.sv - AXI4 slave to AXI4-Lite master bridge, one Lite transaction per burst beat
// Define AXI_LITE_BRIDGE_DEBUG_EN to trace slave-side address and write-data handshakes.
module axi_lite_bridge #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 5,
  parameter int AXI_USER_WIDTH = 1,
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      s_awvalid_i,
  input  logic [1:0]                s_awburst_i,
  input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic [7:0]                s_awlen_i,
  input  logic [2:0]                s_awsize_i,
  input  logic [AXI_ID_WIDTH-1:0]   s_awid_i,
  input  logic [3:0]                s_awcache_i,
  input  logic [2:0]                s_awprot_i,
  input  logic [3:0]                s_awqos_i,
  input  logic [AXI_USER_WIDTH-1:0] s_awuser_i,
  input  logic                      s_awlock_i,
  output logic                      s_awready_o,
  input  logic                      s_wvalid_i,
  input  logic [AXI_STRB_WIDTH-1:0] s_wstrb_i,
  input  logic [AXI_DATA_WIDTH-1:0] s_wdata_i,
  input  logic                      s_wlast_i,
  input  logic [AXI_USER_WIDTH-1:0] s_wuser_i,
  output logic                      s_wready_o,
  input  logic                      s_bready_i,
  output logic                      s_bvalid_o,
  output logic [1:0]                s_bresp_o,
  output logic [AXI_ID_WIDTH-1:0]   s_bid_o,
  output logic [AXI_USER_WIDTH-1:0] s_buser_o,
  input  logic                      s_arvalid_i,
  input  logic [1:0]                s_arburst_i,
  input  logic [AXI_ADDR_WIDTH-1:0] s_araddr_i,
  input  logic [7:0]                s_arlen_i,
  input  logic [2:0]                s_arsize_i,
  input  logic [AXI_ID_WIDTH-1:0]   s_arid_i,
  input  logic [3:0]                s_arcache_i,
  input  logic [2:0]                s_arprot_i,
  input  logic [3:0]                s_arqos_i,
  input  logic [AXI_USER_WIDTH-1:0] s_aruser_i,
  input  logic                      s_arlock_i,
  output logic                      s_arready_o,
  input  logic                      s_rready_i,
  output logic                      s_rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0] s_rdata_o,
  output logic [1:0]                s_rresp_o,
  output logic [AXI_ID_WIDTH-1:0]   s_rid_o,
  output logic                      s_rlast_o,
  output logic [AXI_USER_WIDTH-1:0] s_ruser_o,
  input  logic                      io_awready_i,
  output logic                      io_awvalid_o,
  output logic [AXI_ADDR_WIDTH-1:0] io_awaddr_o,
  input  logic                      io_wready_i,
  output logic                      io_wvalid_o,
  output logic [AXI_STRB_WIDTH-1:0] io_wstrb_o,
  output logic [AXI_DATA_WIDTH-1:0] io_wdata_o,
  input  logic                      io_bvalid_i,
  input  logic [1:0]                io_bresp_i,
  output logic                      io_bready_o,
  input  logic                      io_arready_i,
  output logic                      io_arvalid_o,
  output logic [AXI_ADDR_WIDTH-1:0] io_araddr_o,
  input  logic                      io_rvalid_i,
  input  logic [AXI_DATA_WIDTH-1:0] io_rdata_i,
  input  logic [1:0]                io_rresp_i,
  output logic                      io_rready_o
);
  import axi_lite_bridge_pkg::*;

  logic unused_inputs;
  assign unused_inputs = ^{s_awcache_i, s_awprot_i, s_awqos_i, s_awuser_i, s_awlock_i,
                           s_arcache_i, s_arprot_i, s_arqos_i, s_aruser_i, s_arlock_i,
                           s_wlast_i, s_wuser_i};

  // ---------------- read path ----------------
  rd_state_e                 rd_state_q;
  logic                      s_arready_q, io_arvalid_q, io_rready_q, s_rvalid_q, s_rlast_q;
  logic [AXI_ID_WIDTH-1:0]   rd_id_q;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q;
  logic [7:0]                rd_len_q, rd_beat_q;
  logic [2:0]                rd_size_q;
  logic [1:0]                rd_burst_q, rd_resp_q;
  logic                      rd_err_q;
  logic [AXI_DATA_WIDTH-1:0] rd_data_q;

  // In IDLE the generator looks at the incoming request so the error check is ready at the handshake.
  logic [AXI_ADDR_WIDTH-1:0] rd_gen_addr, rd_next_addr;
  logic [2:0]                rd_gen_size;
  logic [1:0]                rd_gen_burst;
  logic                      rd_gen_err;
  assign rd_gen_addr  = (rd_state_q == RD_IDLE) ? s_araddr_i  : rd_addr_q;
  assign rd_gen_size  = (rd_state_q == RD_IDLE) ? s_arsize_i  : rd_size_q;
  assign rd_gen_burst = (rd_state_q == RD_IDLE) ? s_arburst_i : rd_burst_q;

  axi_lite_bridge_addr_gen #(.ADDR_WIDTH(AXI_ADDR_WIDTH), .STRB_WIDTH(AXI_STRB_WIDTH)) u_rd_gen (
    .addr_i(rd_gen_addr), .size_i(rd_gen_size), .burst_i(rd_gen_burst),
    .next_addr_o(rd_next_addr), .err_o(rd_gen_err)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_state_q   <= RD_IDLE;
      s_arready_q  <= 1'b0;
      io_arvalid_q <= 1'b0;
      io_rready_q  <= 1'b0;
      s_rvalid_q   <= 1'b0;
      s_rlast_q    <= 1'b0;
      rd_id_q      <= '0;
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      rd_beat_q    <= '0;
      rd_size_q    <= '0;
      rd_burst_q   <= '0;
      rd_resp_q    <= '0;
      rd_err_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (s_arvalid_i && s_arready_q) begin
            s_arready_q <= 1'b0;
            rd_id_q     <= s_arid_i;
            rd_addr_q   <= s_araddr_i;
            rd_len_q    <= s_arlen_i;
            rd_size_q   <= s_arsize_i;
            rd_burst_q  <= s_arburst_i;
            rd_beat_q   <= '0;
            rd_err_q    <= rd_gen_err;
            if (rd_gen_err) begin
              rd_data_q  <= '0;
              rd_resp_q  <= RESP_SLVERR;
              s_rvalid_q <= 1'b1;
              s_rlast_q  <= (s_arlen_i == 8'd0);
              rd_state_q <= RD_OUT;
            end else begin
              io_arvalid_q <= 1'b1;
              rd_state_q   <= RD_ADDR;
            end
          end else begin
            s_arready_q <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (io_arready_i) begin
            io_arvalid_q <= 1'b0;
            io_rready_q  <= 1'b1;
            rd_state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (io_rvalid_i) begin
            io_rready_q <= 1'b0;
            rd_data_q   <= io_rdata_i;
            rd_resp_q   <= io_rresp_i;
            s_rvalid_q  <= 1'b1;
            s_rlast_q   <= (rd_beat_q == rd_len_q);
            rd_state_q  <= RD_OUT;
          end
        end
        RD_OUT: begin
          if (s_rready_i) begin
            if (s_rlast_q) begin
              s_rvalid_q <= 1'b0;
              s_rlast_q  <= 1'b0;
              rd_state_q <= RD_IDLE;
            end else begin
              rd_beat_q <= rd_beat_q + 8'd1;
              rd_addr_q <= rd_next_addr;
              if (rd_err_q) begin
                s_rlast_q <= ((rd_beat_q + 8'd1) == rd_len_q);
              end else begin
                s_rvalid_q   <= 1'b0;
                io_arvalid_q <= 1'b1;
                rd_state_q   <= RD_ADDR;
              end
            end
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign s_arready_o  = s_arready_q;
  assign io_arvalid_o = io_arvalid_q;
  assign io_araddr_o  = rd_addr_q;
  assign io_rready_o  = io_rready_q;
  assign s_rvalid_o   = s_rvalid_q;
  assign s_rdata_o    = rd_data_q;
  assign s_rresp_o    = rd_resp_q;
  assign s_rid_o      = rd_id_q;
  assign s_rlast_o    = s_rlast_q;
  assign s_ruser_o    = '0;

  // ---------------- write path ----------------
  wr_state_e                 wr_state_q;
  logic                      s_awready_q, s_wready_q, io_awvalid_q, io_wvalid_q, io_bready_q, s_bvalid_q;
  logic                      aw_done_q, w_done_q, wr_err_q;
  logic [AXI_ID_WIDTH-1:0]   wr_id_q;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]                wr_len_q, wr_beat_q;
  logic [2:0]                wr_size_q;
  logic [1:0]                wr_burst_q, wr_resp_q;
  logic [AXI_DATA_WIDTH-1:0] wr_data_q;
  logic [AXI_STRB_WIDTH-1:0] wr_strb_q;

  logic [AXI_ADDR_WIDTH-1:0] wr_gen_addr, wr_next_addr;
  logic [2:0]                wr_gen_size;
  logic [1:0]                wr_gen_burst;
  logic                      wr_gen_err;
  assign wr_gen_addr  = (wr_state_q == WR_IDLE) ? s_awaddr_i  : wr_addr_q;
  assign wr_gen_size  = (wr_state_q == WR_IDLE) ? s_awsize_i  : wr_size_q;
  assign wr_gen_burst = (wr_state_q == WR_IDLE) ? s_awburst_i : wr_burst_q;

  axi_lite_bridge_addr_gen #(.ADDR_WIDTH(AXI_ADDR_WIDTH), .STRB_WIDTH(AXI_STRB_WIDTH)) u_wr_gen (
    .addr_i(wr_gen_addr), .size_i(wr_gen_size), .burst_i(wr_gen_burst),
    .next_addr_o(wr_next_addr), .err_o(wr_gen_err)
  );

  logic s_w_hs, io_aw_hs, io_w_hs;
  assign s_w_hs   = s_wvalid_i && s_wready_q;
  assign io_aw_hs = io_awvalid_q && io_awready_i;
  assign io_w_hs  = io_wvalid_q && io_wready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_state_q   <= WR_IDLE;
      s_awready_q  <= 1'b0;
      s_wready_q   <= 1'b0;
      io_awvalid_q <= 1'b0;
      io_wvalid_q  <= 1'b0;
      io_bready_q  <= 1'b0;
      s_bvalid_q   <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      wr_id_q      <= '0;
      wr_addr_q    <= '0;
      wr_len_q     <= '0;
      wr_beat_q    <= '0;
      wr_size_q    <= '0;
      wr_burst_q   <= '0;
      wr_resp_q    <= '0;
      wr_data_q    <= '0;
      wr_strb_q    <= '0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (s_awvalid_i && s_awready_q) begin
            s_awready_q  <= 1'b0;
            wr_id_q      <= s_awid_i;
            wr_addr_q    <= s_awaddr_i;
            wr_len_q     <= s_awlen_i;
            wr_size_q    <= s_awsize_i;
            wr_burst_q   <= s_awburst_i;
            wr_beat_q    <= '0;
            wr_resp_q    <= RESP_OKAY;
            wr_err_q     <= wr_gen_err;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            s_wready_q   <= 1'b1;
            io_awvalid_q <= !wr_gen_err;
            wr_state_q   <= WR_BEAT;
          end else begin
            s_awready_q <= 1'b1;
          end
        end
        WR_BEAT: begin
          if (wr_err_q) begin
            // Error bursts drain W beats without any Lite traffic.
            if (s_w_hs) begin
              if (wr_beat_q == wr_len_q) begin
                s_wready_q <= 1'b0;
                wr_resp_q  <= RESP_SLVERR;
                s_bvalid_q <= 1'b1;
                wr_state_q <= WR_BRESP;
              end else begin
                wr_beat_q <= wr_beat_q + 8'd1;
              end
            end
          end else begin
            if (s_w_hs) begin
              wr_data_q   <= s_wdata_i;
              wr_strb_q   <= s_wstrb_i;
              s_wready_q  <= 1'b0;
              io_wvalid_q <= 1'b1;
            end
            if (io_aw_hs) begin
              io_awvalid_q <= 1'b0;
              aw_done_q    <= 1'b1;
            end
            if (io_w_hs) begin
              io_wvalid_q <= 1'b0;
              w_done_q    <= 1'b1;
            end
            if ((aw_done_q || io_aw_hs) && (w_done_q || io_w_hs)) begin
              aw_done_q   <= 1'b0;
              w_done_q    <= 1'b0;
              io_bready_q <= 1'b1;
              wr_state_q  <= WR_LRESP;
            end
          end
        end
        WR_LRESP: begin
          if (io_bvalid_i) begin
            io_bready_q <= 1'b0;
            wr_resp_q   <= resp_max(wr_resp_q, io_bresp_i);
            if (wr_beat_q == wr_len_q) begin
              s_bvalid_q <= 1'b1;
              wr_state_q <= WR_BRESP;
            end else begin
              wr_beat_q    <= wr_beat_q + 8'd1;
              wr_addr_q    <= wr_next_addr;
              io_awvalid_q <= 1'b1;
              s_wready_q   <= 1'b1;
              wr_state_q   <= WR_BEAT;
            end
          end
        end
        WR_BRESP: begin
          if (s_bready_i) begin
            s_bvalid_q <= 1'b0;
            wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  assign s_awready_o  = s_awready_q;
  assign s_wready_o   = s_wready_q;
  assign io_awvalid_o = io_awvalid_q;
  assign io_awaddr_o  = wr_addr_q;
  assign io_wvalid_o  = io_wvalid_q;
  assign io_wdata_o   = wr_data_q;
  assign io_wstrb_o   = wr_strb_q;
  assign io_bready_o  = io_bready_q;
  assign s_bvalid_o   = s_bvalid_q;
  assign s_bresp_o    = wr_resp_q;
  assign s_bid_o      = wr_id_q;
  assign s_buser_o    = '0;

`ifdef AXI_LITE_BRIDGE_DEBUG_EN
  always @(negedge clk_i) begin
    if (!reset_i && s_arvalid_i && s_arready_q && rd_state_q == RD_IDLE)
      $display("axi_lite_bridge: READ Addr %x", s_araddr_i);
    if (!reset_i && s_awvalid_i && s_awready_q && wr_state_q == WR_IDLE)
      $display("WRITE Addr %x", s_awaddr_i);
    if (!reset_i && s_w_hs)
      $display("WRITE Data %x, Strb %x", s_wdata_i, s_wstrb_i);
  end
`else
`endif

endmodule

// File: tb/tb_axi_lite_bridge.sv
// tb/tb_axi_lite_bridge.sv - directed self-checking bench for axi_lite_bridge
module tb_axi_lite_bridge;
  import axi_lite_bridge_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset_i = 1'b1;
  logic        s_awvalid_i = 0, s_awlock_i = 0, s_wvalid_i = 0, s_wlast_i = 0, s_bready_i = 0;
  logic [1:0]  s_awburst_i = 0;
  logic [63:0] s_awaddr_i = 0;
  logic [7:0]  s_awlen_i = 0;
  logic [2:0]  s_awsize_i = 0, s_awprot_i = 0;
  logic [4:0]  s_awid_i = 0;
  logic [3:0]  s_awcache_i = 0, s_awqos_i = 0;
  logic [0:0]  s_awuser_i = 0, s_wuser_i = 0, s_aruser_i = 0;
  logic [7:0]  s_wstrb_i = 0;
  logic [63:0] s_wdata_i = 0;
  logic        s_arvalid_i = 0, s_arlock_i = 0, s_rready_i = 0;
  logic [1:0]  s_arburst_i = 0;
  logic [63:0] s_araddr_i = 0;
  logic [7:0]  s_arlen_i = 0;
  logic [2:0]  s_arsize_i = 0, s_arprot_i = 0;
  logic [4:0]  s_arid_i = 0;
  logic [3:0]  s_arcache_i = 0, s_arqos_i = 0;
  logic        io_awready_i = 0, io_wready_i = 0, io_bvalid_i = 0, io_arready_i = 0, io_rvalid_i = 0;
  logic [1:0]  io_bresp_i = 0, io_rresp_i = 0;
  logic [63:0] io_rdata_i = 0;

  logic        s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o, s_rlast_o;
  logic [1:0]  s_bresp_o, s_rresp_o;
  logic [4:0]  s_bid_o, s_rid_o;
  logic [0:0]  s_buser_o, s_ruser_o;
  logic [63:0] s_rdata_o, io_awaddr_o, io_wdata_o, io_araddr_o;
  logic [7:0]  io_wstrb_o;
  logic        io_awvalid_o, io_wvalid_o, io_bready_o, io_arvalid_o, io_rready_o;

  axi_lite_bridge dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .s_awvalid_i(s_awvalid_i), .s_awburst_i(s_awburst_i), .s_awaddr_i(s_awaddr_i), .s_awlen_i(s_awlen_i),
    .s_awsize_i(s_awsize_i), .s_awid_i(s_awid_i), .s_awcache_i(s_awcache_i), .s_awprot_i(s_awprot_i),
    .s_awqos_i(s_awqos_i), .s_awuser_i(s_awuser_i), .s_awlock_i(s_awlock_i), .s_awready_o(s_awready_o),
    .s_wvalid_i(s_wvalid_i), .s_wstrb_i(s_wstrb_i), .s_wdata_i(s_wdata_i), .s_wlast_i(s_wlast_i),
    .s_wuser_i(s_wuser_i), .s_wready_o(s_wready_o),
    .s_bready_i(s_bready_i), .s_bvalid_o(s_bvalid_o), .s_bresp_o(s_bresp_o), .s_bid_o(s_bid_o), .s_buser_o(s_buser_o),
    .s_arvalid_i(s_arvalid_i), .s_arburst_i(s_arburst_i), .s_araddr_i(s_araddr_i), .s_arlen_i(s_arlen_i),
    .s_arsize_i(s_arsize_i), .s_arid_i(s_arid_i), .s_arcache_i(s_arcache_i), .s_arprot_i(s_arprot_i),
    .s_arqos_i(s_arqos_i), .s_aruser_i(s_aruser_i), .s_arlock_i(s_arlock_i), .s_arready_o(s_arready_o),
    .s_rready_i(s_rready_i), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
    .s_rid_o(s_rid_o), .s_rlast_o(s_rlast_o), .s_ruser_o(s_ruser_o),
    .io_awready_i(io_awready_i), .io_awvalid_o(io_awvalid_o), .io_awaddr_o(io_awaddr_o),
    .io_wready_i(io_wready_i), .io_wvalid_o(io_wvalid_o), .io_wstrb_o(io_wstrb_o), .io_wdata_o(io_wdata_o),
    .io_bvalid_i(io_bvalid_i), .io_bresp_i(io_bresp_i), .io_bready_o(io_bready_o),
    .io_arready_i(io_arready_i), .io_arvalid_o(io_arvalid_o), .io_araddr_o(io_araddr_o),
    .io_rvalid_i(io_rvalid_i), .io_rdata_i(io_rdata_i), .io_rresp_i(io_rresp_i), .io_rready_o(io_rready_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int aw_cycles = 0, ar_cycles = 0, b_hs = 0;

  always @(posedge clk_i) begin
    if (io_awvalid_o) aw_cycles <= aw_cycles + 1;
    if (io_arvalid_o) ar_cycles <= ar_cycles + 1;
    if (s_bvalid_o && s_bready_i) b_hs <= b_hs + 1;
  end

  logic [63:0] cap_addr [4];
  logic [63:0] cap_data [4];
  logic [7:0]  cap_strb [4];
  logic [1:0]  cap_bresp;
  logic [4:0]  cap_bid;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic timeout(input string what);
    n_checks++;
    n_fail++;
    $display("FAIL timeout_%s: no handshake after 100 cycles, required one", what);
  endtask

  task automatic ar_send(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [4:0] id);
    int n = 0;
    s_araddr_i = addr; s_arlen_i = len; s_arsize_i = size; s_arburst_i = burst; s_arid_i = id;
    s_arvalid_i = 1'b1;
    while (s_arready_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("ar");
    tick();
    s_arvalid_i = 1'b0;
  endtask

  task automatic aw_send(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [4:0] id);
    int n = 0;
    s_awaddr_i = addr; s_awlen_i = len; s_awsize_i = size; s_awburst_i = burst; s_awid_i = id;
    s_awvalid_i = 1'b1;
    while (s_awready_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("aw");
    tick();
    s_awvalid_i = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb);
    int n = 0;
    s_wdata_i = data; s_wstrb_i = strb; s_wvalid_i = 1'b1;
    while (s_wready_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("w");
    tick();
    s_wvalid_i = 1'b0;
  endtask

  task automatic lite_read(input logic [63:0] data, input logic [1:0] resp, output logic [63:0] addr);
    int n = 0;
    while (io_arvalid_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("io_ar");
    addr = io_araddr_o;
    io_arready_i = 1'b1; tick(); io_arready_i = 1'b0;
    n = 0;
    while (io_rready_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("io_r");
    io_rdata_i = data; io_rresp_i = resp; io_rvalid_i = 1'b1;
    tick();
    io_rvalid_i = 1'b0;
  endtask

  task automatic r_take(output logic [63:0] data, output logic [1:0] resp, output logic last,
                        output logic [4:0] id);
    int n = 0;
    while (s_rvalid_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("s_r");
    data = s_rdata_o; resp = s_rresp_o; last = s_rlast_o; id = s_rid_o;
    s_rready_i = 1'b1; tick(); s_rready_i = 1'b0;
  endtask

  task automatic lite_write(input logic [1:0] resp, output logic [63:0] addr, output logic [63:0] data,
                            output logic [7:0] strb);
    int n = 0;
    while (io_awvalid_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("io_aw");
    addr = io_awaddr_o;
    io_awready_i = 1'b1; tick(); io_awready_i = 1'b0;
    n = 0;
    while (io_wvalid_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("io_w");
    data = io_wdata_o; strb = io_wstrb_o;
    io_wready_i = 1'b1; tick(); io_wready_i = 1'b0;
    n = 0;
    while (io_bready_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("io_b");
    io_bresp_i = resp; io_bvalid_i = 1'b1;
    tick();
    io_bvalid_i = 1'b0;
  endtask

  task automatic b_take(output logic [1:0] resp, output logic [4:0] id);
    int n = 0;
    while (s_bvalid_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) timeout("s_b");
    resp = s_bresp_o; id = s_bid_o;
    s_bready_i = 1'b1; tick(); s_bready_i = 1'b0;
  endtask

  task automatic write_incr4(input logic [1:0] beat2_resp, input logic [4:0] id);
    aw_send(64'h4000_0000, 8'd3, 3'd3, BURST_INCR, id);
    for (int i = 0; i < 4; i++) begin
      w_send(64'(i + 1), 8'hFF);
      lite_write((i == 2) ? beat2_resp : RESP_OKAY, cap_addr[i], cap_data[i], cap_strb[i]);
    end
    b_take(cap_bresp, cap_bid);
  endtask

  task automatic test_reset();
    logic [9:0] hs;
    reset_i = 1'b1;
    tick(); tick(); tick();
    hs = {s_arready_o, s_awready_o, s_wready_o, s_rvalid_o, s_bvalid_o,
          io_awvalid_o, io_wvalid_o, io_bready_o, io_arvalid_o, io_rready_o};
    n_checks++;
    if (hs !== 10'b0) begin n_fail++; $display("FAIL reset_handshakes: got %b, expected 0", hs); end
    n_checks++;
    if ({s_ruser_o, s_buser_o, s_rlast_o} !== 3'b0) begin
      n_fail++; $display("FAIL reset_user: got %b, expected 000", {s_ruser_o, s_buser_o, s_rlast_o});
    end
    reset_i = 1'b0;
    tick(); tick();
    n_checks++;
    if ({s_arready_o, s_awready_o, s_wready_o} !== 3'b110) begin
      n_fail++; $display("FAIL idle_ready: got %b, expected 110", {s_arready_o, s_awready_o, s_wready_o});
    end
  endtask

  task automatic test_single_read();
    logic [63:0] a, d; logic [1:0] r; logic l; logic [4:0] id;
    ar_send(64'h4000_0010, 8'd0, 3'd3, BURST_INCR, 5'd5);
    n_checks++;
    if (io_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL ar_latency: io_arvalid %b, expected 1", io_arvalid_o); end
    lite_read(64'hDEAD_BEEF, RESP_OKAY, a);
    n_checks++;
    if (s_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL r_latency: s_rvalid %b, expected 1", s_rvalid_o); end
    r_take(d, r, l, id);
    n_checks++;
    if (a !== 64'h4000_0010) begin n_fail++; $display("FAIL single_araddr: got %h, expected 4000_0010", a); end
    n_checks++;
    if (d !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h, expected DEADBEEF", d); end
    n_checks++;
    if ({l, id, r} !== {1'b1, 5'd5, 2'd0}) begin
      n_fail++; $display("FAIL single_rmeta: last/id/resp %b/%0d/%0d, expected 1/5/0", l, id, r);
    end
  endtask

  task automatic test_incr_write();
    int b0 = b_hs;
    write_incr4(RESP_OKAY, 5'd9);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (cap_addr[i] !== 64'h4000_0000 + 64'(8 * i) || cap_data[i] !== 64'(i + 1) || cap_strb[i] !== 8'hFF) begin
        n_fail++;
        $display("FAIL incr_beat%0d: addr %h data %h strb %h, expected %h %h ff", i, cap_addr[i], cap_data[i],
                 cap_strb[i], 64'h4000_0000 + 64'(8 * i), 64'(i + 1));
      end
    end
    n_checks++;
    if (cap_bresp !== RESP_OKAY || cap_bid !== 5'd9) begin
      n_fail++; $display("FAIL incr_b: resp %0d id %0d, expected 0 9", cap_bresp, cap_bid);
    end
    n_checks++;
    if (b_hs - b0 !== 1) begin n_fail++; $display("FAIL incr_bcount: got %0d, expected 1", b_hs - b0); end
  endtask

  task automatic test_resp_agg();
    write_incr4(RESP_SLVERR, 5'd3);
    n_checks++;
    if (cap_bresp !== RESP_SLVERR || cap_bid !== 5'd3) begin
      n_fail++; $display("FAIL agg_b: resp %0d id %0d, expected 2 3", cap_bresp, cap_bid);
    end
  endtask

  task automatic test_fixed_read();
    logic [63:0] a, d; logic [1:0] r; logic l; logic [4:0] id;
    ar_send(64'h4000_0008, 8'd1, 3'd3, BURST_FIXED, 5'd2);
    for (int i = 0; i < 2; i++) begin
      lite_read(64'h1111 * 64'(i + 1), RESP_OKAY, a);
      r_take(d, r, l, id);
      n_checks++;
      if (a !== 64'h4000_0008 || d !== 64'h1111 * 64'(i + 1) || l !== (i == 1) || id !== 5'd2) begin
        n_fail++;
        $display("FAIL fixed_beat%0d: addr %h data %h last %b id %0d, expected 4000_0008 %h %b 2",
                 i, a, d, l, id, 64'h1111 * 64'(i + 1), (i == 1));
      end
    end
  endtask

  task automatic test_wrap_write();
    int c0 = aw_cycles;
    logic [1:0] r; logic [4:0] id;
    aw_send(64'h4000_0020, 8'd1, 3'd3, BURST_WRAP, 5'd7);
    w_send(64'hA1, 8'hFF);
    w_send(64'hA2, 8'hFF);
    b_take(r, id);
    n_checks++;
    if (r !== RESP_SLVERR || id !== 5'd7) begin n_fail++; $display("FAIL wrap_b: resp %0d id %0d, expected 2 7", r, id); end
    n_checks++;
    if (aw_cycles !== c0) begin n_fail++; $display("FAIL wrap_no_lite: io_awvalid cycles %0d, expected 0", aw_cycles - c0); end
  endtask

  task automatic test_error_read();
    int c0 = ar_cycles;
    logic [63:0] d; logic [1:0] r; logic l; logic [4:0] id;
    ar_send(64'h4000_0030, 8'd1, 3'd4, BURST_INCR, 5'd4);
    for (int i = 0; i < 2; i++) begin
      r_take(d, r, l, id);
      n_checks++;
      if (d !== 64'd0 || r !== RESP_SLVERR || l !== (i == 1) || id !== 5'd4) begin
        n_fail++; $display("FAIL errread_beat%0d: data %h resp %0d last %b id %0d, expected 0 2 %b 4", i, d, r, l, id, (i == 1));
      end
    end
    n_checks++;
    if (ar_cycles !== c0) begin n_fail++; $display("FAIL errread_no_lite: io_arvalid cycles %0d, expected 0", ar_cycles - c0); end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, d; logic [1:0] r; logic l; logic [4:0] id;
    int bad = 0;
    ar_send(64'h4000_0040, 8'd0, 3'd3, BURST_INCR, 5'd1);
    lite_read(64'hCAFE_F00D_1234_5678, RESP_OKAY, a);
    for (int i = 0; i < 10; i++) begin
      if (s_rvalid_o !== 1'b1 || s_rdata_o !== 64'hCAFE_F00D_1234_5678) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad); end
    r_take(d, r, l, id);
    n_checks++;
    if (d !== 64'hCAFE_F00D_1234_5678 || l !== 1'b1) begin
      n_fail++; $display("FAIL bp_data: data %h last %b, expected cafef00d12345678 1", d, l);
    end
  endtask

  task automatic test_concurrent();
    logic [63:0] a, d, wd; logic [7:0] ws; logic [1:0] r; logic l; logic [4:0] id;
    tick();
    s_araddr_i = 64'h4000_0200; s_arlen_i = 0; s_arsize_i = 3; s_arburst_i = BURST_INCR; s_arid_i = 5'd10;
    s_awaddr_i = 64'h4000_0300; s_awlen_i = 0; s_awsize_i = 3; s_awburst_i = BURST_INCR; s_awid_i = 5'd11;
    s_arvalid_i = 1'b1; s_awvalid_i = 1'b1;
    n_checks++;
    if ({s_arready_o, s_awready_o} !== 2'b11) begin
      n_fail++; $display("FAIL conc_ready: got %b, expected 11", {s_arready_o, s_awready_o});
    end
    tick();
    s_arvalid_i = 1'b0; s_awvalid_i = 1'b0;
    n_checks++;
    if ({io_arvalid_o, io_awvalid_o} !== 2'b11) begin
      n_fail++; $display("FAIL conc_issue: got %b, expected 11", {io_arvalid_o, io_awvalid_o});
    end
    lite_read(64'h77, RESP_OKAY, a);
    r_take(d, r, l, id);
    w_send(64'h88, 8'h0F);
    lite_write(RESP_OKAY, a, wd, ws);
    b_take(r, id);
    n_checks++;
    if (d !== 64'h77 || a !== 64'h4000_0300 || wd !== 64'h88 || r !== RESP_OKAY || id !== 5'd11) begin
      n_fail++; $display("FAIL conc_done: rdata %h awaddr %h wdata %h bresp %0d bid %0d, expected 77 4000_0300 88 0 11",
                         d, a, wd, r, id);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] a, d; logic [7:0] s; logic [1:0] r; logic [4:0] id;
    aw_send(64'h4000_0080, 8'd0, 3'd3, BURST_INCR, 5'd6);
    w_send(64'hAA, 8'hFF);
    io_awready_i = 1'b1; tick(); io_awready_i = 1'b0;
    io_wready_i = 1'b1; tick(); io_wready_i = 1'b0;
    n_checks++;
    if (io_bready_o !== 1'b1) begin n_fail++; $display("FAIL mid_lresp: io_bready %b, expected 1", io_bready_o); end
    reset_i = 1'b1;
    tick();
    n_checks++;
    if ({s_bvalid_o, s_rvalid_o, io_awvalid_o, io_wvalid_o, io_arvalid_o, io_bready_o, s_awready_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got %b, expected 0",
               {s_bvalid_o, s_rvalid_o, io_awvalid_o, io_wvalid_o, io_arvalid_o, io_bready_o, s_awready_o});
    end
    reset_i = 1'b0;
    tick();
    aw_send(64'h4000_0100, 8'd0, 3'd3, BURST_INCR, 5'd12);
    w_send(64'h55, 8'h0F);
    lite_write(RESP_OKAY, a, d, s);
    b_take(r, id);
    n_checks++;
    if (a !== 64'h4000_0100 || d !== 64'h55 || s !== 8'h0F || r !== RESP_OKAY || id !== 5'd12) begin
      n_fail++; $display("FAIL post_reset_write: addr %h data %h strb %h resp %0d id %0d, expected 4000_0100 55 0f 0 12",
                         a, d, s, r, id);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_incr_write();
    test_resp_agg();
    test_fixed_read();
    test_wrap_write();
    test_error_read();
    test_backpressure();
    test_concurrent();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
